bcd_counter_display: RTL and testbench
======================================

# bcd_counter_display

Parametrised N-digit BCD up/down counter that drives N multiplexed-free 7-segment digits directly from debounced push-buttons. It has increment, decrement and clear inputs and auto-repeat when a button is held. It sits between the board switches and the segment pins and replaces the fixed two-digit, increment-only counter. It instantiates the existing `Debounce_Switch` once per button.

## Interface
- `NUM_DIGITS`, 2: number of BCD digits (1–8); digit 0 is least significant.
- `DEBOUNCE_LIMIT`, 250000: cycles an input must be stable; passed to each `Debounce_Switch`.
- `REPEAT_DELAY`, 12500000: cycles a single held button waits after its first step before auto-repeat starts.
- `REPEAT_RATE`, 2500000: cycles between auto-repeat steps.

Ports:
- `i_Clk`  in  1: system clock.
- `i_Rst_L`  in  1: synchronous, active-low reset.
- `i_Switch_Inc`  in  1: raw increment button, active-high.
- `i_Switch_Dec`  in  1: raw decrement button, active-high.
- `i_Switch_Clr`  in  1: raw clear button, active-high.
- `o_Segments`  out  7*NUM_DIGITS: active-low segments. Digit d occupies [7d+6:7d], with bit 0 = A through bit 6 = G.
- `o_Count_Bcd`  out  4*NUM_DIGITS: registered BCD count; digit d occupies [4d+3:4d].
- `o_Wrap`  out  1: one-cycle pulse on rollover in either direction.

## Operation
- Each raw input passes through its own `Debounce_Switch`. Debounced signals are registered once for edge detection.
- Count semantics:
  - The count is a decimal value 0 to 10^NUM_DIGITS − 1. Every nibble is always in the range 0–9.
  - A step applies a decimal ripple carry or borrow across the digits in a single cycle.
- Wrap behaviour:
  - Increment from all-9s gives all-0s, with `o_Wrap`=1 for one cycle.
  - Decrement from all-0s gives all-9s, with `o_Wrap`=1 for one cycle.
- Priority:
  - Debounced Clr is level-sensitive. While it is high: count = 0, FSM forced to IDLE, all steps suppressed. Clearing never pulses `o_Wrap`.
  - If debounced Inc and Dec are both high, no step occurs and the FSM goes to or stays in IDLE.
- Auto-repeat FSM, with a shared cycle counter wide enough for max(REPEAT_DELAY, REPEAT_RATE):
  - IDLE: on the rising edge of exactly one of Inc/Dec, take one step in that direction, load counter = REPEAT_DELAY−1, go to DELAY.
  - DELAY: if the same button is still held and the counter reaches 0, take one step, load REPEAT_RATE−1, go to REPEAT. Otherwise decrement the counter.
  - REPEAT: if held and the counter reaches 0, take one step and reload REPEAT_RATE−1.
  - In DELAY or REPEAT: release, a second button, or Clr sends the FSM to IDLE the next cycle with no step.
  - The held direction is latched on IDLE exit. The other button's edge is ignored until IDLE.
- Decode: each nibble maps to the standard patterns. For values 0–9, active-high patterns are: 0=7'h3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. These are inverted on output. Any nibble value above 9 (never reachable) decodes to all segments off.

## Timing
- Reset (`i_Rst_L`=0 at a clock edge): count = 0, FSM = IDLE, repeat counter = 0, edge registers = 0, `o_Wrap`=0.
  - `o_Segments` shows "0" on every digit: 7'b1000000 per digit.
  - Reset mid-repeat aborts with no step. Debouncer state also resets.
- A raw button must be stable for DEBOUNCE_LIMIT cycles before its debounced level changes.
- Latency, counted from the cycle the debounced level rises:
  - `o_Count_Bcd` and `o_Wrap` update one cycle later.
  - `o_Segments` updates two cycles later, because the decode is registered.
- Held button: step 1 at the edge; step 2 REPEAT_DELAY cycles after step 1; each later step every REPEAT_RATE cycles.
- Clr assertion: count reads 0 one cycle after the debounced Clr rises.
- `o_Wrap` is high only in the cycle in which the wrapped count first appears.

## Test plan
Bench parameters: NUM_DIGITS=2, DEBOUNCE_LIMIT=4, REPEAT_DELAY=20, REPEAT_RATE=5.

- Reset, then idle for 10 cycles: expect `o_Count_Bcd`=8'h00 and `o_Segments`=14'b1000000_1000000.
- Ten short Inc presses, each held 8 cycles: count goes 01…09, then 10. The digit-1 segments show "1" (7'b1111001) two cycles after the count changes.
- Preload to 99 by presses, then one more Inc: count 00 with a single-cycle `o_Wrap`. Then one Dec from 00: count 99 with `o_Wrap`.
- Hold Inc for 60 cycles after debounce, starting from 00: expect steps at t=1, 21, 26, 31, …, i.e. 9 steps total. Count is then 09, and stays unchanged after release.
- Bounce Inc: toggle every 2 cycles for 20 cycles, then release. Expect no count change. Then hold Inc and Dec together: no step.
- Hold Inc into auto-repeat, assert Clr mid-repeat: count becomes 00 one cycle after debounced Clr, with no `o_Wrap`. After Clr is released with Inc still held, no steps occur until Inc is released and pressed again.

Source files
------------

// File: rtl/bcd_counter_display.sv
// N-digit BCD up/down counter with per-button debouncing, hold-to-repeat and
// registered active-low 7-segment outputs.

module Debounce_Switch #(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Switch
);
  localparam int CW = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;

  logic [CW-1:0] r_Count;
  logic          r_State;

  // The output follows the input only after it has differed for DEBOUNCE_LIMIT consecutive cycles
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_Count <= '0;
      r_State <= 1'b0;
    end else if (i_Switch != r_State) begin
      if (r_Count == CW'(DEBOUNCE_LIMIT - 1)) begin
        r_State <= i_Switch;
        r_Count <= '0;
      end else begin
        r_Count <= r_Count + 1'b1;
      end
    end else begin
      r_Count <= '0;
    end
  end

  assign o_Switch = r_State;
endmodule

module bcd_counter_display #(
  parameter int NUM_DIGITS     = 2,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int REPEAT_DELAY   = 12500000,
  parameter int REPEAT_RATE    = 2500000
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic                    i_Switch_Inc,
  input  logic                    i_Switch_Dec,
  input  logic                    i_Switch_Clr,
  output logic [7*NUM_DIGITS-1:0] o_Segments,
  output logic [4*NUM_DIGITS-1:0] o_Count_Bcd,
  output logic                    o_Wrap
);
  localparam int MAXC = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int NB   = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  // Returns {wrap, next_count}: decimal ripple across all digits in one cycle.
  function automatic logic [NB:0] bcd_step(input logic [NB-1:0] v, input logic up);
    logic [NB-1:0] res;
    logic          c;
    logic [3:0]    nib;
    res = v;
    c   = 1'b1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      nib = v[4*d +: 4];
      if (c) begin
        if (up) begin
          if (nib == 4'd9) begin
            res[4*d +: 4] = 4'd0;
          end else begin
            res[4*d +: 4] = nib + 4'd1;
            c             = 1'b0;
          end
        end else begin
          if (nib == 4'd0) begin
            res[4*d +: 4] = 4'd9;
          end else begin
            res[4*d +: 4] = nib - 4'd1;
            c             = 1'b0;
          end
        end
      end else begin
        res[4*d +: 4] = nib;
      end
    end
    return {c, res};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  logic          w_Inc, w_Dec, w_Clr;
  logic          r_Inc_Q, r_Dec_Q;
  logic          w_Rise_Inc, w_Rise_Dec, w_Held;
  state_t        r_State, w_Next_State;
  logic          r_Dir, w_Next_Dir;
  logic [CW-1:0] r_Rpt_Cnt, w_Next_Cnt;
  logic          w_Step, w_Step_Up;
  logic [NB:0]   w_Stepped;
  logic [NB-1:0] r_Count;
  logic          r_Wrap;
  logic [7*NUM_DIGITS-1:0] r_Seg;

  Debounce_Switch #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_db_inc (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Switch(i_Switch_Inc), .o_Switch(w_Inc));
  Debounce_Switch #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_db_dec (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Switch(i_Switch_Dec), .o_Switch(w_Dec));
  Debounce_Switch #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_db_clr (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Switch(i_Switch_Clr), .o_Switch(w_Clr));

  assign w_Rise_Inc = w_Inc & ~r_Inc_Q;
  assign w_Rise_Dec = w_Dec & ~r_Dec_Q;
  // Hold continues only while the latched button alone is down.
  assign w_Held     = r_Dir ? (w_Inc & ~w_Dec) : (w_Dec & ~w_Inc);
  assign w_Stepped  = bcd_step(r_Count, w_Step_Up);

  // Auto-repeat next-state and step decision
  always_comb begin
    w_Next_State = r_State;
    w_Next_Dir   = r_Dir;
    w_Next_Cnt   = r_Rpt_Cnt;
    w_Step       = 1'b0;
    w_Step_Up    = r_Dir;
    if (w_Clr) begin
      w_Next_State = S_IDLE;
      w_Next_Cnt   = '0;
    end else begin
      case (r_State)
        S_IDLE: begin
          if (w_Rise_Inc && !w_Dec) begin
            w_Step       = 1'b1;
            w_Step_Up    = 1'b1;
            w_Next_Dir   = 1'b1;
            w_Next_Cnt   = CW'(REPEAT_DELAY - 1);
            w_Next_State = S_DELAY;
          end else if (w_Rise_Dec && !w_Inc) begin
            w_Step       = 1'b1;
            w_Step_Up    = 1'b0;
            w_Next_Dir   = 1'b0;
            w_Next_Cnt   = CW'(REPEAT_DELAY - 1);
            w_Next_State = S_DELAY;
          end else begin
            w_Next_State = S_IDLE;
          end
        end
        S_DELAY, S_REPEAT: begin
          if (!w_Held) begin
            w_Next_State = S_IDLE;
          end else if (r_Rpt_Cnt == '0) begin
            w_Step       = 1'b1;
            w_Next_Cnt   = CW'(REPEAT_RATE - 1);
            w_Next_State = S_REPEAT;
          end else begin
            w_Next_Cnt   = r_Rpt_Cnt - 1'b1;
          end
        end
        default: begin
          w_Next_State = S_IDLE;
        end
      endcase
    end
  end

  // FSM state, latched direction, shared repeat counter and edge registers
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_State   <= S_IDLE;
      r_Dir     <= 1'b0;
      r_Rpt_Cnt <= '0;
      r_Inc_Q   <= 1'b0;
      r_Dec_Q   <= 1'b0;
    end else begin
      r_State   <= w_Next_State;
      r_Dir     <= w_Next_Dir;
      r_Rpt_Cnt <= w_Next_Cnt;
      r_Inc_Q   <= w_Inc;
      r_Dec_Q   <= w_Dec;
    end
  end

  // Count register and wrap pulse; clear wins over any step
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_Count <= '0;
      r_Wrap  <= 1'b0;
    end else if (w_Clr) begin
      r_Count <= '0;
      r_Wrap  <= 1'b0;
    end else if (w_Step) begin
      r_Count <= w_Stepped[NB-1:0];
      r_Wrap  <= w_Stepped[NB];
    end else begin
      r_Wrap  <= 1'b0;
    end
  end

  // Registered decode of the count, inverted for active-low segments
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_Seg <= {NUM_DIGITS{7'b1000000}};
    end else begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        r_Seg[7*d +: 7] <= ~seg7(r_Count[4*d +: 4]);
      end
    end
  end

  assign o_Count_Bcd = r_Count;
  assign o_Wrap      = r_Wrap;
  assign o_Segments  = r_Seg;
endmodule

// File: tb/tb_bcd_counter_display.sv
// Randomised and directed bench for bcd_counter_display against a decimal
// behavioural model of debounce, hold-to-repeat and display.

module tb_bcd_counter_display;
  localparam int ND = 2;
  localparam int DL = 4;
  localparam int RD = 20;
  localparam int RR = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic inc = 1'b0, dec = 1'b0, clr = 1'b0;
  logic [7*ND-1:0] seg;
  logic [4*ND-1:0] cnt;
  logic            wrap;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  int wrap_seen = 0;

  // Model state
  int   m_val = 0;
  bit   m_wrap = 1'b0;
  logic [13:0] m_seg = 14'b1000000_1000000;
  int   db_cnt [3] = '{0, 0, 0};
  bit   db [3] = '{1'b0, 1'b0, 1'b0};
  bit   prv [3] = '{1'b0, 1'b0, 1'b0};
  bit   odb [3];
  bit   raw [3];
  bit   held = 1'b0;
  bit   hdir = 1'b0;
  int   wait_c = 0;

  bcd_counter_display #(
    .NUM_DIGITS(ND), .DEBOUNCE_LIMIT(DL), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .i_Clk(clk), .i_Rst_L(rst_n),
    .i_Switch_Inc(inc), .i_Switch_Dec(dec), .i_Switch_Clr(clr),
    .o_Segments(seg), .o_Count_Bcd(cnt), .o_Wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] seg_of(input int v);
    logic [6:0] pat [10];
    pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return {~pat[v / 10], ~pat[v % 10]};
  endfunction

  function automatic logic [7:0] bcd_of(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic m_step(input bit up);
    if (up) begin
      if (m_val == 99) begin m_val = 0; m_wrap = 1'b1; end
      else m_val = m_val + 1;
    end else begin
      if (m_val == 0) begin m_val = 99; m_wrap = 1'b1; end
      else m_val = m_val - 1;
    end
  endtask

  // Reference model: advances one clock using the inputs seen at that edge
  always @(posedge clk) begin
    raw = '{inc, dec, clr};
    odb = db;
    if (!rst_n) begin
      m_val = 0; m_wrap = 1'b0; m_seg = seg_of(0);
      db_cnt = '{0, 0, 0}; db = '{1'b0, 1'b0, 1'b0}; prv = '{1'b0, 1'b0, 1'b0};
      held = 1'b0; wait_c = 0;
    end else begin
      m_seg  = seg_of(m_val);
      m_wrap = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (raw[i] != db[i]) begin
          db_cnt[i] = db_cnt[i] + 1;
          if (db_cnt[i] == DL) begin db[i] = raw[i]; db_cnt[i] = 0; end
        end else begin
          db_cnt[i] = 0;
        end
      end
      if (odb[2]) begin
        m_val = 0; held = 1'b0;
      end else if (!held) begin
        if (odb[0] && !prv[0] && !odb[1]) begin
          m_step(1'b1); held = 1'b1; hdir = 1'b1; wait_c = RD;
        end else if (odb[1] && !prv[1] && !odb[0]) begin
          m_step(1'b0); held = 1'b1; hdir = 1'b0; wait_c = RD;
        end
      end else begin
        if (hdir ? (odb[0] && !odb[1]) : (odb[1] && !odb[0])) begin
          wait_c = wait_c - 1;
          if (wait_c == 0) begin m_step(hdir); wait_c = RR; end
        end else begin
          held = 1'b0;
        end
      end
      prv = odb;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", 32'(cnt), 32'(bcd_of(m_val)));
      chk("wrap", 32'(wrap), 32'(m_wrap));
      chk("segments", 32'(seg), 32'(m_seg));
      if (wrap === 1'b1) wrap_seen = wrap_seen + 1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit b_inc, input bit b_dec, input bit b_clr, input int hold, input int gap);
    inc = b_inc; dec = b_dec; clr = b_clr;
    cyc(hold);
    inc = 1'b0; dec = 1'b0; clr = 1'b0;
    cyc(gap);
  endtask

  initial begin
    int n;
    int h;
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    chk_en = 1'b1;
    cyc(10);
    chk("reset_count", 32'(cnt), 32'h00);
    chk("reset_seg", 32'(seg), 32'(14'b1000000_1000000));

    for (int i = 0; i < 10; i++) press(1'b1, 1'b0, 1'b0, 8, 12);
    chk("ten_inc_count", 32'(cnt), 32'h10);
    chk("ten_inc_digit1", 32'(seg[13:7]), 32'(7'b1111001));

    for (int i = 0; i < 10; i++) press(1'b0, 1'b1, 1'b0, 8, 12);
    chk("back_to_zero", 32'(cnt), 32'h00);
    wrap_seen = 0;
    press(1'b0, 1'b1, 1'b0, 8, 12);
    chk("dec_wrap_99", 32'(cnt), 32'h99);
    press(1'b1, 1'b0, 1'b0, 8, 12);
    chk("inc_wrap_00", 32'(cnt), 32'h00);
    press(1'b0, 1'b1, 1'b0, 8, 12);
    chk("dec_wrap_99b", 32'(cnt), 32'h99);
    press(1'b1, 1'b0, 1'b0, 8, 12);
    chk("inc_wrap_00b", 32'(cnt), 32'h00);
    chk("wrap_pulses", 32'(wrap_seen), 32'd4);

    inc = 1'b1;
    n = 0;
    while (!db[0] && n < 20) begin cyc(1); n++; end
    chk("debounce_wait", 32'(db[0]), 32'd1);
    cyc(54);
    inc = 1'b0;
    cyc(15);
    chk("hold_count", 32'(cnt), 32'h09);
    cyc(10);
    chk("hold_after_release", 32'(cnt), 32'h09);

    for (int i = 0; i < 10; i++) begin inc = ~inc; cyc(2); end
    inc = 1'b0;
    cyc(12);
    chk("bounce_no_step", 32'(cnt), 32'h09);
    press(1'b1, 1'b1, 1'b0, 30, 12);
    chk("both_no_step", 32'(cnt), 32'h09);

    wrap_seen = 0;
    inc = 1'b1;
    cyc(40);
    clr = 1'b1;
    cyc(10);
    chk("clr_count", 32'(cnt), 32'h00);
    clr = 1'b0;
    cyc(40);
    chk("clr_then_held", 32'(cnt), 32'h00);
    chk("clr_no_wrap", 32'(wrap_seen), 32'd0);
    inc = 1'b0;
    cyc(12);
    press(1'b1, 1'b0, 1'b0, 8, 12);
    chk("repress_after_clr", 32'(cnt), 32'h01);

    for (int i = 0; i < 40; i++) begin
      h = $urandom_range(1, 50);
      if (i == 20) begin
        inc = 1'b1;
        cyc(35);
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        inc = 1'b0;
        cyc(12);
        chk("reset_mid_repeat", 32'(cnt), 32'h00);
      end else if ($urandom_range(0, 5) == 0) begin
        for (int k = 0; k < h / 2; k++) begin
          dec = ($urandom_range(0, 1) == 1);
          cyc(1);
        end
        dec = 1'b0;
        cyc(10);
      end else begin
        press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 7) == 0), h, $urandom_range(1, 20));
      end
    end
    cyc(20);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
